// File: rtl/mem_port_arb_if.sv
// rtl/mem_port_arb_if.sv - single-ported memory bus driven by mem_port_arb
interface mem_port_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();
   logic                m_valid;
   logic                m_ready;
   logic                m_we;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_wstrb;
   logic                m_rvalid;
   logic [DATA_W-1:0]   m_rdata;

   modport master (
      output m_valid, m_we, m_addr, m_wdata, m_wstrb,
      input  m_ready, m_rvalid, m_rdata
   );

   modport slave (
      input  m_valid, m_we, m_addr, m_wdata, m_wstrb,
      output m_ready, m_rvalid, m_rdata
   );
endinterface

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - fixed-priority fetch/data arbiter sequencing one memory transaction at a time
module mem_port_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic                i_kill,
   output logic [DATA_W-1:0]   i_rdata,
   output logic                i_done,
   output logic                stall_i,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_done,
   output logic                stall_d,
   mem_port_arb_if.master      mem
);
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

   state_e              state_q, state_d;
   logic                owner_d_q, owner_d_d;
   logic                drop_q, drop_d;
   logic                m_we_q, m_we_d;
   logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic [DATA_W/8-1:0] m_wstrb_q, m_wstrb_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         owner_d_q <= 1'b0;
         drop_q    <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         drop_q    <= drop_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      drop_d    = drop_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;

      case (state_q)
         ST_IDLE: begin
            // Data access belongs to the older instruction, so it wins.
            if (d_req) begin
               state_d   = ST_REQ;
               owner_d_d = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_wstrb_d = d_wstrb;
            end else if (i_req && !i_kill) begin
               state_d   = ST_REQ;
               owner_d_d = 1'b0;
               m_we_d    = 1'b0;
               m_addr_d  = i_addr;
               m_wdata_d = '0;
               m_wstrb_d = '0;
            end
         end
         ST_REQ: begin
            if (mem.m_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem.m_rvalid) begin
               state_d = ST_RESP;
               if (owner_d_q) d_rdata_d = mem.m_rdata;
               else           i_rdata_d = mem.m_rdata;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A flushed fetch still finishes on the bus; only its completion is hidden.
      if ((state_q == ST_REQ || state_q == ST_WAIT) && !owner_d_q && i_kill) drop_d = 1'b1;
      if (state_d == ST_IDLE) drop_d = 1'b0;
   end

   assign mem.m_valid = (state_q == ST_REQ);
   assign mem.m_we    = m_we_q;
   assign mem.m_addr  = m_addr_q;
   assign mem.m_wdata = m_wdata_q;
   assign mem.m_wstrb = m_wstrb_q;

   assign d_done  = (state_q == ST_RESP) && owner_d_q;
   assign i_done  = (state_q == ST_RESP) && !owner_d_q && !drop_q && !i_kill;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign stall_i = i_req & ~i_done;
   assign stall_d = d_req & ~d_done;
endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - directed and randomized checks of mem_port_arb against a transaction-level model
module tb_mem_port_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_kill, i_done, stall_i;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_done, stall_d;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   int          n_run = 0;
   int          n_fail = 0;

   mem_port_arb_if #(.ADDR_W(32), .DATA_W(32)) mem ();

   mem_port_arb #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata), .i_done(i_done), .stall_i(stall_i),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_rdata(d_rdata), .d_done(d_done), .stall_d(stall_d),
      .mem(mem)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1);
   end

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_req = 0; i_addr = 0; i_kill = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
      mem.m_ready = 0; mem.m_rvalid = 0; mem.m_rdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; mem.m_rvalid = 1; mem.m_ready = 1;
      cyc_start();
      cyc_start();
      mid();
      n_run++; if (mem.m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mvalid got=%0b want=0", mem.m_valid); end
      n_run++; if ({mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb} !== 69'd0) begin n_fail++; $display("FAIL rst_payload got=%0h want=0", {mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb}); end
      n_run++; if ({i_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done got=%b want=00", {i_done, d_done}); end
      n_run++; if ({i_rdata, d_rdata} !== 64'd0) begin n_fail++; $display("FAIL rst_rdata got=%0h want=0", {i_rdata, d_rdata}); end
      rst = 0; idle_inputs();
      cyc_start();
   endtask

   task automatic test_single_fetch();
      i_req = 1; i_addr = 32'h100; mem.m_ready = 1;
      mid();
      n_run++; if (stall_i !== 1'b1) begin n_fail++; $display("FAIL sf_stall_c0 got=%0b want=1", stall_i); end
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_we, mem.m_addr} !== {2'b10, 32'h100}) begin n_fail++; $display("FAIL sf_req_c1 got=%0h want=%0h", {mem.m_valid, mem.m_we, mem.m_addr}, {2'b10, 32'h100}); end
      n_run++; if (stall_i !== 1'b1) begin n_fail++; $display("FAIL sf_stall_c1 got=%0b want=1", stall_i); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = 32'h13; mid();
      n_run++; if ({stall_i, i_done} !== 2'b10) begin n_fail++; $display("FAIL sf_c2 got=%b want=10", {stall_i, i_done}); end
      cyc_start(); mem.m_rvalid = 0; mem.m_rdata = 32'hFFFF_FFFF; mid();
      n_run++; if ({i_done, stall_i} !== 2'b10) begin n_fail++; $display("FAIL sf_done_c3 got=%b want=10", {i_done, stall_i}); end
      n_run++; if (i_rdata !== 32'h13) begin n_fail++; $display("FAIL sf_rdata got=%h want=00000013", i_rdata); end
      cyc_start(); idle_inputs(); mid();
      n_run++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL sf_done_c4 got=%0b want=0", i_done); end
      cyc_start();
   endtask

   task automatic test_simultaneous();
      i_req = 1; i_addr = 32'h104;
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
      mem.m_ready = 1;
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb} !== {2'b11, 32'h2000, 32'hDEADBEEF, 4'hF}) begin n_fail++; $display("FAIL sim_store_req got=%h want=%h", {mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb}, {2'b11, 32'h2000, 32'hDEADBEEF, 4'hF}); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = 32'h0; mid();
      n_run++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL sim_ddone_c2 got=%0b want=0", d_done); end
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({d_done, stall_d, i_done, stall_i} !== 4'b1001) begin n_fail++; $display("FAIL sim_c3 got=%b want=1001", {d_done, stall_d, i_done, stall_i}); end
      cyc_start(); d_req = 0; mid();
      n_run++; if (mem.m_valid !== 1'b0) begin n_fail++; $display("FAIL sim_mvalid_c4 got=%0b want=0", mem.m_valid); end
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_we, mem.m_addr, mem.m_wstrb} !== {2'b10, 32'h104, 4'h0}) begin n_fail++; $display("FAIL sim_fetch_c5 got=%h want=%h", {mem.m_valid, mem.m_we, mem.m_addr, mem.m_wstrb}, {2'b10, 32'h104, 4'h0}); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = 32'h17; mid();
      n_run++; if (i_done !== 1'b0) begin n_fail++; $display("FAIL sim_idone_c6 got=%0b want=0", i_done); end
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({i_done, d_done, i_rdata} !== {2'b10, 32'h17}) begin n_fail++; $display("FAIL sim_c7 got=%h want=%h", {i_done, d_done, i_rdata}, {2'b10, 32'h17}); end
      cyc_start(); idle_inputs();
      cyc_start();
   endtask

   task automatic test_backpressure();
      int accepts = 0;
      d_req = 1; d_we = 0; d_addr = 32'h3000; mem.m_ready = 0;
      cyc_start();
      for (int c = 1; c <= 6; c++) begin
         mem.m_ready = (c >= 4);
         mem.m_rvalid = (c == 5);
         mem.m_rdata = (c == 5) ? 32'h31 : 32'hEEEE_EEEE;
         mid();
         if (mem.m_valid && mem.m_ready) accepts++;
         if (c <= 4) begin
            n_run++; if ({mem.m_valid, mem.m_addr} !== {1'b1, 32'h3000}) begin n_fail++; $display("FAIL bp_hold c%0d got=%h want=%h", c, {mem.m_valid, mem.m_addr}, {1'b1, 32'h3000}); end
         end
         n_run++; if (d_done !== (c == 6)) begin n_fail++; $display("FAIL bp_ddone c%0d got=%0b want=%0b", c, d_done, (c == 6)); end
         if (c == 6) begin
            n_run++; if (d_rdata !== 32'h31) begin n_fail++; $display("FAIL bp_rdata got=%h want=00000031", d_rdata); end
         end
         cyc_start();
      end
      n_run++; if (accepts !== 1) begin n_fail++; $display("FAIL bp_accepts got=%0d want=1", accepts); end
      idle_inputs();
      cyc_start();
   endtask

   task automatic test_kill_in_flight();
      i_req = 1; i_addr = 32'h108; mem.m_ready = 1;
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_addr} !== {1'b1, 32'h108}) begin n_fail++; $display("FAIL kill_req got=%h want=%h", {mem.m_valid, mem.m_addr}, {1'b1, 32'h108}); end
      cyc_start();
      for (int c = 2; c <= 4; c++) begin
         i_req = 0;
         i_kill = (c == 2);
         mem.m_rvalid = (c == 3);
         mem.m_rdata = 32'hAAAA_AAAA;
         mid();
         n_run++; if ({i_done, stall_i} !== 2'b00) begin n_fail++; $display("FAIL kill_nodone c%0d got=%b want=00", c, {i_done, stall_i}); end
         cyc_start();
      end
      i_kill = 0; mem.m_rvalid = 0;
      i_req = 1; i_addr = 32'h200;
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_addr} !== {1'b1, 32'h200}) begin n_fail++; $display("FAIL kill_refetch got=%h want=%h", {mem.m_valid, mem.m_addr}, {1'b1, 32'h200}); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = 32'h55;
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({i_done, i_rdata} !== {1'b1, 32'h55}) begin n_fail++; $display("FAIL kill_refetch_done got=%h want=%h", {i_done, i_rdata}, {1'b1, 32'h55}); end
      cyc_start(); idle_inputs();
      cyc_start();
   endtask

   task automatic test_reset_mid_wait();
      d_req = 1; d_we = 0; d_addr = 32'h40; mem.m_ready = 1;
      cyc_start();
      cyc_start();
      d_req = 0; rst = 1;
      cyc_start();
      rst = 0; mem.m_rvalid = 1; mem.m_rdata = 32'hBAD;
      mid();
      n_run++; if ({mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb} !== 70'd0) begin n_fail++; $display("FAIL rmw_bus got=%h want=0", {mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb}); end
      n_run++; if ({d_done, i_done, d_rdata, i_rdata} !== 66'd0) begin n_fail++; $display("FAIL rmw_outs got=%h want=0", {d_done, i_done, d_rdata, i_rdata}); end
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({d_done, mem.m_valid} !== 2'b00) begin n_fail++; $display("FAIL rmw_stale got=%b want=00", {d_done, mem.m_valid}); end
      cyc_start(); d_req = 1;
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_addr} !== {1'b1, 32'h40}) begin n_fail++; $display("FAIL rmw_reissue got=%h want=%h", {mem.m_valid, mem.m_addr}, {1'b1, 32'h40}); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = 32'h77; mid();
      n_run++; if (d_done !== 1'b0) begin n_fail++; $display("FAIL rmw_early got=%0b want=0", d_done); end
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({d_done, d_rdata} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL rmw_done got=%h want=%h", {d_done, d_rdata}, {1'b1, 32'h77}); end
      cyc_start(); idle_inputs();
      cyc_start();
   endtask

   task automatic test_byte_store();
      d_req = 1; d_we = 1; d_addr = 32'h2002; d_wdata = 32'h00AB_0000; d_wstrb = 4'b0100; mem.m_ready = 1;
      cyc_start(); mid();
      n_run++; if ({mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb} !== {2'b11, 32'h2002, 32'h00AB_0000, 4'b0100}) begin n_fail++; $display("FAIL bs_req got=%h want=%h", {mem.m_valid, mem.m_we, mem.m_addr, mem.m_wdata, mem.m_wstrb}, {2'b11, 32'h2002, 32'h00AB_0000, 4'b0100}); end
      cyc_start(); mem.m_rvalid = 1; mem.m_rdata = $urandom;
      cyc_start(); mem.m_rvalid = 0; mid();
      n_run++; if ({d_done, stall_d} !== 2'b10) begin n_fail++; $display("FAIL bs_done got=%b want=10", {d_done, stall_d}); end
      cyc_start(); idle_inputs();
      cyc_start();
   endtask

   task automatic test_random();
      logic [31:0] mem_m [16];
      bit          d_act, i_act, busy, accepted, responded, own_d, killed;
      int          free_cyc, grant_cyc, accept_cyc, resp_cyc, rv_delay, n_txn, idx;
      logic        e_we, exp_mv, exp_dd, exp_id;
      logic [31:0] e_addr, e_wdata, e_rdata;
      logic [3:0]  e_wstrb;
      for (int k = 0; k < 16; k++) mem_m[k] = 32'hA500_0000 ^ (k * 32'h0101_0101);
      d_act = 0; i_act = 0; busy = 0; accepted = 0; responded = 0; own_d = 0; killed = 0;
      free_cyc = 0; grant_cyc = 0; accept_cyc = 0; resp_cyc = 0; rv_delay = 0; n_txn = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_rdata = 0; e_wstrb = 0;
      idle_inputs(); rst = 1;
      cyc_start(); rst = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!d_act && $urandom_range(2) == 0) begin
            d_act = 1; d_we = 1'($urandom_range(1));
            d_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
            d_wdata = $urandom; d_wstrb = 4'($urandom_range(15));
         end
         d_req = d_act;
         if (!i_act && $urandom_range(2) == 0) begin
            i_act = 1; i_addr = {26'h0, 4'($urandom_range(15)), 2'b00};
         end
         i_req = i_act;
         i_kill = ($urandom_range(9) == 0);
         mem.m_ready = 1'($urandom_range(1));
         if (!busy && cyc >= free_cyc && (d_req || (i_req && !i_kill))) begin
            busy = 1; accepted = 0; responded = 0; killed = 0; grant_cyc = cyc; own_d = d_req;
            if (d_req) begin e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_wstrb = d_wstrb; end
            else begin e_we = 0; e_addr = i_addr; e_wdata = 0; e_wstrb = 0; end
         end
         if (busy && accepted && !responded && cyc >= accept_cyc + 1 + rv_delay) begin
            idx = int'(e_addr[5:2]);
            if (e_we) begin
               for (int b = 0; b < 4; b++) if (e_wstrb[b]) mem_m[idx][8*b +: 8] = e_wdata[8*b +: 8];
               e_rdata = $urandom;
            end else begin
               e_rdata = mem_m[idx];
            end
            mem.m_rvalid = 1; mem.m_rdata = e_rdata; responded = 1; resp_cyc = cyc;
         end else begin
            mem.m_rvalid = (!busy || !accepted || responded) ? ($urandom_range(3) == 0) : 1'b0;
            mem.m_rdata = $urandom;
         end
         mid();
         exp_mv = busy && cyc > grant_cyc && !accepted;
         n_run++; if (mem.m_valid !== exp_mv) begin n_fail++; $display("FAIL rnd_mvalid cyc=%0d got=%0b want=%0b", cyc, mem.m_valid, exp_mv); end
         if (exp_mv) begin
            n_run++; if ({mem.m_we, mem.m_addr, mem.m_wstrb} !== {e_we, e_addr, e_wstrb}) begin n_fail++; $display("FAIL rnd_payload cyc=%0d got=%h want=%h", cyc, {mem.m_we, mem.m_addr, mem.m_wstrb}, {e_we, e_addr, e_wstrb}); end
            if (e_we) begin
               n_run++; if (mem.m_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h want=%h", cyc, mem.m_wdata, e_wdata); end
            end
            if (mem.m_ready) begin accepted = 1; accept_cyc = cyc; rv_delay = $urandom_range(2); end
         end
         if (busy && !own_d && cyc > grant_cyc && i_kill) killed = 1;
         exp_dd = busy && responded && cyc == resp_cyc + 1 && own_d;
         exp_id = busy && responded && cyc == resp_cyc + 1 && !own_d && !killed;
         n_run++; if ({d_done, i_done} !== {exp_dd, exp_id}) begin n_fail++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", cyc, {d_done, i_done}, {exp_dd, exp_id}); end
         if (exp_dd && !e_we) begin
            n_run++; if (d_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_drdata cyc=%0d got=%h want=%h", cyc, d_rdata, e_rdata); end
         end
         if (exp_id) begin
            n_run++; if (i_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_irdata cyc=%0d got=%h want=%h", cyc, i_rdata, e_rdata); end
         end
         n_run++; if ({stall_d, stall_i} !== {d_req && !exp_dd, i_req && !exp_id}) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", cyc, {stall_d, stall_i}, {d_req && !exp_dd, i_req && !exp_id}); end
         if (busy && responded && cyc == resp_cyc + 1) begin busy = 0; free_cyc = cyc + 1; n_txn++; end
         if (exp_dd) d_act = 0;
         if (exp_id || i_kill) i_act = 0;
         cyc_start();
      end
      n_run++; if (n_txn < 100) begin n_fail++; $display("FAIL rnd_progress got=%0d want>=100", n_txn); end
      idle_inputs();
      cyc_start();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_backpressure();
      test_kill_in_flight();
      test_reset_mid_wait();
      test_byte_store();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Fixed-priority arbiter and sequencer that shares one single-ported memory bus between the pipeline's instruction-fetch port and data-memory port. It accepts one transaction at a time, drives the memory handshake, and returns read data or write acknowledgement to the owner. It produces per-port stall signals that the hazard logic ORs into `stall_f`/`stall_d` (fetch) and the MEM-stage stall (data). On a branch flush it discards an in-flight fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_done` or `i_kill`
- `i_addr`  in  ADDR_W  fetch address
- `i_kill`  in  1  fetch flush (pcsrc); cancels the pending or in-flight fetch
- `i_rdata`  out  DATA_W  fetched word; valid only while `i_done`
- `i_done`  out  1  one-cycle fetch completion
- `stall_i`  out  1  `i_req & ~i_done`
- `d_req`  in  1  data request; held with the operands until `d_done`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  store byte enables
- `d_rdata`  out  DATA_W  load data; valid only while `d_done`
- `d_done`  out  1  one-cycle data completion (loads and stores)
- `stall_d`  out  1  `d_req & ~d_done`
- `m_valid`  out  1  memory request valid
- `m_ready`  in  1  memory accepts request when `m_valid & m_ready`
- `m_we`, `m_addr`, `m_wdata`, `m_wstrb`  out  1/ADDR_W/DATA_W/DATA_W/8  request payload
- `m_rvalid`  in  1  response; one per accepted request, including stores
- `m_rdata`  in  DATA_W  read data; ignored for stores

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE → REQ when a request is granted.
  - REQ → WAIT on `m_valid & m_ready`.
  - WAIT → RESP on `m_rvalid`.
  - RESP → IDLE unconditionally.
- Grant, evaluated only in IDLE:
  - `d_req` wins first. The data access belongs to the older instruction.
  - Otherwise `i_req & ~i_kill` is granted.
  - Otherwise the FSM stays in IDLE.
- On grant, register the owner (I/D) and the payload from the owner's inputs. A fetch registers `m_we=0` and `m_wstrb=0`.
- `m_valid` is 1 exactly in REQ. The payload is constant from entry to REQ until acceptance.
- On `m_rvalid` in WAIT, register `m_rdata` into the owner's rdata register.
- In RESP:
  - `d_done = owner_D`.
  - `i_done = owner_I & ~drop & ~i_kill`.
- `drop` flag:
  - Set when `i_kill` is high while owner=I in REQ or WAIT.
  - Cleared on entry to IDLE.
  - A killed fetch still completes its bus transaction. It is never retracted, because `m_valid` cannot drop before acceptance.
- No new grant in RESP. This keeps the requester's stale `*_req` from being re-issued.
- `m_rvalid` outside WAIT is ignored. `m_ready` outside REQ is ignored.
- `stall_i` and `stall_d` are combinational from the inputs and the done outputs. Both are low whenever the corresponding request is low.

## Timing
- Reset values:
  - State IDLE.
  - `m_valid=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`, `m_wstrb=0`.
  - `i_done=0`, `d_done=0`, `i_rdata=0`, `d_rdata=0`, `drop=0`.
- A reset asserted in any state reaches these values on the next edge. A later `m_rvalid` from the aborted transaction is ignored.
- Minimum latency, with `m_ready=1` and `m_rvalid` in the cycle after acceptance:
  - Request sampled at cycle 0.
  - `m_valid` at cycle 1.
  - WAIT at cycle 2, `m_rvalid` at cycle 2.
  - Done at cycle 3.
- Earliest next grant is cycle 4 (IDLE). Back-to-back throughput is one transaction per 4 cycles.
- Each cycle of `m_ready=0` or `m_rvalid` delay adds one cycle.
- If `i_kill` and `i_req` are both high in IDLE with no `d_req`: no grant.

## Test plan
- **Single fetch, zero-wait.** `i_req`, `i_addr=0x100` at c0; `m_ready=1`; `m_rvalid` with `m_rdata=0x00000013` at c2.
  - Required: `m_valid=1`, `m_addr=0x100`, `m_we=0` at c1.
  - Required: `i_done=1` and `i_rdata=0x13` at c3.
  - Required: `stall_i` high c0–c2, low c3.
- **Simultaneous requests.** `i_req` at 0x104 and a `d_req` store to 0x2000, `d_wdata=0xDEADBEEF`, `d_wstrb=0xF`, both at c0.
  - Required: store issued first, with `m_we=1` and the payload exact; `d_done` at c3.
  - Required: fetch `m_valid` at c5; `i_done` at c7.
- **Backpressure.** `d_req` load from 0x3000 with `m_ready=0` for 3 cycles.
  - Required: `m_valid` and `m_addr=0x3000` stable all 4 REQ cycles; exactly one acceptance.
  - Required: `d_done` 3 cycles later than zero-wait.
- **Kill in flight.** Fetch 0x108; `i_kill` pulsed during WAIT; response 0xAAAA_AAAA arrives.
  - Required: no `i_done`, `stall_i=0` while `i_req=0`.
  - Then `i_req` at 0x200 with response 0x55: `i_done` with `i_rdata=0x55`.
- **Reset mid-WAIT.** Load outstanding; `rst` for 1 cycle; `m_rvalid` arrives after reset.
  - Required: all outputs at reset values.
  - Required: no `d_done` until the load is reissued.
- **Byte store.** `d_wstrb=4'b0100`, `d_addr=0x2002`.
  - Required: `m_wstrb=4'b0100` and `m_addr=0x2002` unchanged.
  - Required: `d_done` on the write-ack `m_rvalid`; `d_rdata` not checked.
